// File: rtl/alu_result_queue.sv
// Result FIFO behind the 32-bit ALU: buffers result, flags and command per accepted op,
// and tracks sticky carry/overflow plus a saturating count of accepted operations.
module alu_result_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_result,
  input  logic                     in_carryout,
  input  logic                     in_zero,
  input  logic                     in_overflow,
  input  logic [2:0]               in_command,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic                     out_carryout,
  output logic                     out_zero,
  output logic                     out_overflow,
  output logic [2:0]               out_command,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     sticky_carry,
  output logic                     sticky_overflow,
  input  logic                     clear_sticky,
  output logic [CNT_W-1:0]         op_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carryout;
    logic             zero;
    logic             overflow;
    logic [2:0]       command;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_sticky_carry;
  logic             r_sticky_overflow;
  logic [CNT_W-1:0] r_op_count;

  logic   w_push;
  logic   w_pop;
  logic   w_arith;
  logic   w_carry_m;
  logic   w_ovf_m;
  entry_t w_entry;
  entry_t w_head;

  // Carry and overflow only mean something for ADD/SUB; everything else stores them as 0.
  assign w_arith   = (in_command == 3'd0) || (in_command == 3'd1);
  assign w_carry_m = in_carryout & w_arith;
  assign w_ovf_m   = in_overflow & w_arith;

  assign in_ready  = (r_count != FULL_COUNT);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign w_entry = '{result: in_result, carryout: w_carry_m, zero: in_zero,
                     overflow: w_ovf_m, command: in_command};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr          <= '0;
      r_rd_ptr          <= '0;
      r_count           <= '0;
      r_sticky_carry    <= 1'b0;
      r_sticky_overflow <= 1'b0;
      r_op_count        <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (AW+1)'(1);
      end
      // A flag being pushed in the same cycle as a clear survives the clear.
      r_sticky_carry    <= (r_sticky_carry & ~clear_sticky) | (w_push & w_carry_m);
      r_sticky_overflow <= (r_sticky_overflow & ~clear_sticky) | (w_push & w_ovf_m);
      if (w_push && (r_op_count != '1)) begin
        r_op_count <= r_op_count + CNT_W'(1);
      end
    end
  end

  // Mask the head so the outputs read as zero whenever the queue is empty.
  assign w_head = out_valid ? r_mem[r_rd_ptr] : '0;

  assign out_result      = w_head.result;
  assign out_carryout    = w_head.carryout;
  assign out_zero        = w_head.zero;
  assign out_overflow    = w_head.overflow;
  assign out_command     = w_head.command;
  assign count           = r_count;
  assign sticky_carry    = r_sticky_carry;
  assign sticky_overflow = r_sticky_overflow;
  assign op_count        = r_op_count;

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed bench for alu_result_queue: linear steps with hand-computed expectations.
module tb_alu_result_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_carryout;
  logic        in_zero;
  logic        in_overflow;
  logic [2:0]  in_command;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_carryout;
  logic        out_zero;
  logic        out_overflow;
  logic [2:0]  out_command;
  logic [2:0]  count;
  logic        sticky_carry;
  logic        sticky_overflow;
  logic        clear_sticky;
  logic [15:0] op_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_result_queue #(.WIDTH(32), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_carryout(in_carryout), .in_zero(in_zero), .in_overflow(in_overflow),
    .in_command(in_command),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carryout(out_carryout), .out_zero(out_zero), .out_overflow(out_overflow),
    .out_command(out_command), .count(count),
    .sticky_carry(sticky_carry), .sticky_overflow(sticky_overflow),
    .clear_sticky(clear_sticky), .op_count(op_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic c,
                       input logic z, input logic o, input logic [2:0] cmd);
    in_valid    = v;
    in_result   = res;
    in_carryout = c;
    in_zero     = z;
    in_overflow = o;
    in_command  = cmd;
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b0;
    clear_sticky = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_op_count", 64'(op_count), 64'(0));
    check("rst_out_result", 64'(out_result), 64'(0));
    check("rst_sticky", 64'({sticky_carry, sticky_overflow}), 64'(0));
    reset = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    $display("step reset: count=%0d op_count=%0d", count, op_count);

    // Single ADD
    drive(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 3'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    check("add_out_valid", 64'(out_valid), 64'(1));
    check("add_out_result", 64'(out_result), 64'hFFFF_FFFE);
    check("add_out_carry", 64'(out_carryout), 64'(1));
    check("add_count", 64'(count), 64'(1));
    check("add_sticky_carry", 64'(sticky_carry), 64'(1));
    check("add_op_count", 64'(op_count), 64'(1));
    $display("step add: result=%h carry=%0b", out_result, out_carryout);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("add_pop_count", 64'(count), 64'(0));
    check("add_pop_result", 64'(out_result), 64'(0));

    // Clear sticky, then masking with XOR
    clear_sticky = 1'b1;
    tick();
    clear_sticky = 1'b0;
    check("clr_sticky_carry", 64'(sticky_carry), 64'(0));
    drive(1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 3'd2);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    check("xor_carry", 64'(out_carryout), 64'(0));
    check("xor_ovf", 64'(out_overflow), 64'(0));
    check("xor_zero", 64'(out_zero), 64'(1));
    check("xor_cmd", 64'(out_command), 64'(2));
    check("xor_sticky", 64'({sticky_carry, sticky_overflow}), 64'(0));
    check("xor_op_count", 64'(op_count), 64'(2));
    $display("step xor: carry=%0b ovf=%0b zero=%0b", out_carryout, out_overflow, out_zero);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Fill to full with AND results 1..4
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i), 1'b0, 1'b0, 1'b0, 3'd4);
      tick();
      $display("step fill: pushed %0d count=%0d", i, count);
    end
    check("full_count", 64'(count), 64'(4));
    check("full_in_ready", 64'(in_ready), 64'(0));
    drive(1'b1, 32'd5, 1'b0, 1'b0, 1'b0, 3'd4);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    check("full_reject_count", 64'(count), 64'(4));
    check("full_reject_opcnt", 64'(op_count), 64'(6));
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_head", 64'(out_result), 64'(i));
      $display("step drain: head=%0d", out_result);
      tick();
    end
    out_ready = 1'b0;
    check("drain_count", 64'(count), 64'(0));
    check("drain_out_valid", 64'(out_valid), 64'(0));
    check("drain_out_result", 64'(out_result), 64'(0));

    // Fresh start so op_count counts only the concurrent-traffic pushes
    reset = 1'b1;
    #1;
    reset = 1'b0;
    drive(1'b1, 32'd10, 1'b0, 1'b0, 1'b0, 3'd7);
    tick();
    drive(1'b1, 32'd11, 1'b0, 1'b0, 1'b0, 3'd7);
    tick();
    check("conc_pre_count", 64'(count), 64'(2));
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 32'(12 + k), 1'b0, 1'b0, 1'b0, 3'd7);
      check("conc_head", 64'(out_result), 64'(10 + k));
      tick();
      check("conc_count", 64'(count), 64'(2));
      $display("step concurrent %0d: count=%0d head=%0d", k, count, out_result);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    check("conc_op_count", 64'(op_count), 64'(8));
    check("conc_tail0", 64'(out_result), 64'(16));
    tick();
    check("conc_tail1", 64'(out_result), 64'(17));
    tick();
    check("conc_empty", 64'(count), 64'(0));

    // Clear vs set on overflow
    drive(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 3'd1);
    tick();
    check("sub_sticky_ovf", 64'(sticky_overflow), 64'(1));
    check("sub_head_ovf", 64'(out_overflow), 64'(1));
    clear_sticky = 1'b1;
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    check("clr_vs_set_ovf", 64'(sticky_overflow), 64'(1));
    tick();
    clear_sticky = 1'b0;
    check("clr_alone_ovf", 64'(sticky_overflow), 64'(0));
    $display("step clear: sticky_overflow=%0b", sticky_overflow);
    out_ready = 1'b0;
    check("clr_count", 64'(count), 64'(0));

    // Reset mid-stream with three entries queued
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(32'h100 + i), 1'b0, 1'b0, 1'b0, 3'd0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    check("mid_count", 64'(count), 64'(3));
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_count", 64'(count), 64'(0));
    check("mid_rst_opcnt", 64'(op_count), 64'(0));
    check("mid_rst_result", 64'(out_result), 64'(0));
    #1;
    reset = 1'b0;
    drive(1'b1, 32'h0000_ABCD, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    check("post_rst_head", 64'(out_result), 64'h0000_ABCD);
    check("post_rst_count", 64'(count), 64'(1));
    $display("step reset-mid: head=%h count=%0d", out_result, count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_queue.md
Name: alu_result_queue

Overview:
Downstream stage of the 32-bit ALU. It captures each ALU result with its carryout, zero and overflow flags and the command that produced it, tagged by a valid/ready handshake. Entries are buffered in a small FIFO for the consumer (register writeback / flag logic). The block also keeps sticky arithmetic status and an operation counter. Command encoding matches the ALU: ADD=0, SUB=1, XOR=2, SLT=3, AND=4, NAND=5, NOR=6, OR=7.

Parameters:
WIDTH, 32, datapath width of result
DEPTH, 4, FIFO entries; must be a power of two, minimum 2
CNT_W, 16, width of the accepted-operation counter

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  producer has an ALU result this cycle
in_ready  output  1  block can accept an entry this cycle
in_result  input  WIDTH  ALU result
in_carryout  input  1  ALU carryout
in_zero  input  1  ALU zero flag
in_overflow  input  1  ALU overflow flag
in_command  input  3  ALU command that produced the result
out_valid  output  1  head entry is valid
out_ready  input  1  consumer takes head entry this cycle
out_result  output  WIDTH  head result
out_carryout  output  1  head carryout (masked)
out_zero  output  1  head zero flag
out_overflow  output  1  head overflow (masked)
out_command  output  3  head command
count  output  log2(DEPTH)+1  current occupancy
sticky_carry  output  1  OR of masked carryout over all accepted entries since last clear
sticky_overflow  output  1  OR of masked overflow over all accepted entries since last clear
clear_sticky  input  1  synchronous clear of both sticky bits
op_count  output  CNT_W  number of accepted entries; saturating

Behaviour:
- Reset (async, active-high): count=0, read/write pointers=0, out_valid=0, out_result=0, out_* flags=0, out_command=0, sticky_carry=0, sticky_overflow=0, op_count=0, in_ready=1 once reset deasserts.
- Push when in_valid && in_ready at a rising edge. Pop when out_valid && out_ready at a rising edge.
- in_ready = (count != DEPTH). It depends only on state, never on out_ready. When the FIFO is full, a pop that cycle does not allow a push.
- Flag masking at push: carryout and overflow are stored as given only for ADD or SUB. For every other command they are stored as 0. Zero is stored unmasked. Result and command are stored unmodified.
- Latency: an entry pushed at edge N is visible on out_* with out_valid=1 immediately after edge N when the FIFO was empty (1-cycle latency). There is no combinational bypass from in_* to out_*.
- out_* shows the head entry whenever count>0. It is all zeros when empty; out_valid=0 when empty.
- Ordering is strict FIFO. Pointers wrap modulo DEPTH.
- Simultaneous push and pop with 0<count<DEPTH: count is unchanged and both pointers advance.
- Push into empty FIFO with out_ready=1: no pop that cycle, because out_valid was 0.
- Pop on empty and push on full are impossible by the handshake. Ignore out_ready when out_valid=0, and ignore in_valid when in_ready=0.
- Sticky bits: on a push, each sticky bit ORs in the masked flag being pushed. clear_sticky zeroes both bits at the edge. If clear_sticky and a push with a masked flag of 1 happen in the same cycle, the bit ends at 1 (set wins).
- op_count increments by 1 per push and saturates at all ones. It is not cleared by clear_sticky.
- Reset mid-operation discards all entries. Outputs return to reset values asynchronously, with no completion of any handshake in progress.

Test Plan:
- Single ADD: push result=32'hFFFFFFFE, carry=1, ovf=0, zero=0, cmd=0 with out_ready=0. After 1 edge: out_valid=1, out_result=FFFFFFFE, out_carryout=1, count=1, sticky_carry=1, op_count=1.
- Masking: push cmd=XOR(2), carry=1, ovf=1, zero=1. Required: out_carryout=0, out_overflow=0, out_zero=1, and sticky bits unchanged from 0.
- Fill/drain: out_ready=0, push 4 entries with results 1,2,3,4. Required: in_ready=0 with count=4 after the 4th, and a 5th in_valid is not accepted. Then out_ready=1: results 1,2,3,4 drain in order over 4 cycles, count reaches 0, out_valid=0, out_result=0.
- Concurrent push/pop: with count=2 steady, hold in_valid=1 and out_ready=1 for 6 cycles. Required: count stays 2 throughout, order is preserved across pointer wrap, op_count=8.
- Clear vs set: sticky_overflow=1; in the same cycle assert clear_sticky and push SUB with ovf=1. Required: sticky_overflow=1. Next cycle, clear_sticky alone gives sticky_overflow=0.
- Reset mid-stream: with count=3, assert reset between edges. Required: out_valid=0, count=0, op_count=0 immediately, and the next push after release appears as the head.
